// File: rtl/alu_defs.sv
// -----------------------------------------------------------------------------
// alu_defs
//   Shared definitions for the ALU operation scheduler slice.
//   - OP_W / DATA_W : default opcode and operand widths of the shared ALU
//   - CNT_W         : width of the execute-cycle down-counter (EXEC_CYCLES <= 4)
//   - opcode_t      : the eight ALU operation codes (select line = 1 << code)
//   - state_t       : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package alu_defs;

    localparam int OP_W   = 3;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Purely combinational 4-way round-robin arbiter. Searches req starting at
//   index ptr and moving upward with wrap-around; the first asserted request
//   wins.
//   Ports:
//     req    [3:0] in  : request vector
//     ptr    [1:0] in  : highest-priority index for this decision
//     gnt    [3:0] out : one-hot grant, all-zero when req is all-zero
//     gnt_id [1:0] out : encoded grant index (equals ptr when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt    = '0;
        gnt_id = ptr;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            // 2-bit addition wraps 3 -> 0 naturally
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
//   Shares one ALU datapath among four requesters. One operation is accepted
//   at a time (round-robin), its one-hot select and operands are driven to the
//   ALU for EXEC_CYCLES cycles, the result is captured on the last execute
//   edge and returned, tagged with the requester index, through a
//   valid/ready response port.
//   Ports:
//     clk, rst_n             : clock, asynchronous active-low reset
//     req_valid / req_ready  : per-requester handshake (at most one ready)
//     req_op, req_a, req_b   : packed per-requester opcode and operands
//     alu_sel                : one-hot op select (zero outside EXEC)
//     alu_a, alu_b           : operands to the ALU (hold last latched values)
//     alu_result, alu_cout   : ALU outputs, sampled on the last EXEC edge
//     rsp_valid / rsp_ready  : response handshake
//     rsp_id, rsp_result,
//     rsp_cout               : captured response, stable while rsp_valid
// -----------------------------------------------------------------------------
module alu_op_scheduler #(
    parameter int N_REQ       = 4,
    parameter int OP_W        = 3,
    parameter int DATA_W      = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    output logic [(1<<OP_W)-1:0]     alu_sel,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_id,
    output logic [DATA_W-1:0]        rsp_result,
    output logic                     rsp_cout
);

    import alu_defs::*;

    localparam int SEL_W = 1 << OP_W;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rr_ptr;
    logic [3:0]        gnt;
    logic [1:0]        gnt_id;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        id_q;
    logic [CNT_W-1:0]  exec_cnt;
    logic              accept;
    logic              exec_done;

    rr_arbiter_4 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Grant is only offered while idle and out of reset, so nothing can be
    // accepted while rst_n is held low.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n) begin
            req_ready = gnt;
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign exec_done = (state == EXEC) && (exec_cnt == '0);
    assign rsp_valid = (state == RESP);

    always_comb begin
        alu_sel = '0;
        if (state == EXEC) begin
            alu_sel = SEL_W'(1) << op_q;
        end
    end

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next-state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = EXEC;
            EXEC: if (exec_done) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // ---- accept stage: latch the granted request and advance the pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            op_q   <= '0;
            id_q   <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (accept) begin
            rr_ptr <= gnt_id + 2'd1;
            op_q   <= req_op[gnt_id*OP_W +: OP_W];
            id_q   <= gnt_id;
            alu_a  <= req_a[gnt_id*DATA_W +: DATA_W];
            alu_b  <= req_b[gnt_id*DATA_W +: DATA_W];
        end
    end

    // ---- execute stage: count down the hold window ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt <= '0;
        end else if (accept) begin
            exec_cnt <= CNT_W'(EXEC_CYCLES - 1);
        end else if (state == EXEC && exec_cnt != '0) begin
            exec_cnt <= exec_cnt - 1'b1;
        end
    end

    // ---- response stage: capture on the last execute edge, hold in RESP ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else if (exec_done) begin
            rsp_id     <= id_q;
            rsp_result <= alu_result;
            rsp_cout   <= alu_cout;
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;

    typedef struct {
        logic [1:0] id;
        logic [3:0] res;
        logic       cout;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic glitch;

    // Instance with EXEC_CYCLES = 1
    logic [3:0]  req_valid, req_ready;
    logic [11:0] req_op;
    logic [15:0] req_a, req_b;
    logic [7:0]  alu_sel;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic        alu_cout;
    logic        rsp_valid, rsp_ready, rsp_cout;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_result;

    // Instance with EXEC_CYCLES = 3
    logic [3:0]  req_valid_3, req_ready_3;
    logic [11:0] req_op_3;
    logic [15:0] req_a_3, req_b_3;
    logic [7:0]  alu_sel_3;
    logic [3:0]  alu_a_3, alu_b_3, alu_result_3;
    logic        alu_cout_3;
    logic        rsp_valid_3, rsp_ready_3, rsp_cout_3;
    logic [1:0]  rsp_id_3;
    logic [3:0]  rsp_result_3;

    int checks;
    int errors;
    exp_t q1[$];
    exp_t q3[$];
    exp_t m1_e;
    exp_t m3_e;
    int rr_order[5] = '{0, 1, 2, 3, 0};

    alu_op_scheduler #(.N_REQ(4), .OP_W(3), .DATA_W(4), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cout(rsp_cout)
    );

    alu_op_scheduler #(.N_REQ(4), .OP_W(3), .DATA_W(4), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req_op(req_op_3), .req_a(req_a_3), .req_b(req_b_3),
        .alu_sel(alu_sel_3), .alu_a(alu_a_3), .alu_b(alu_b_3),
        .alu_result(alu_result_3), .alu_cout(alu_cout_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
        .rsp_id(rsp_id_3), .rsp_result(rsp_result_3), .rsp_cout(rsp_cout_3)
    );

    // Reference ALU: returns {cout, result}
    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (op)
            3'd0:    r = 5'(a) + 5'(b);
            3'd1:    r = 5'(a) - 5'(b);
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {a, 1'b0};
            default: r = {a[0], 1'b0, a[3:1]};
        endcase
        return r;
    endfunction

    function automatic logic [4:0] alu_env(input logic [7:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) r = alu_f(3'(i), a, b);
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [1:0] id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [4:0] r;
        r      = alu_f(op, a, b);
        e.id   = id;
        e.res  = r[3:0];
        e.cout = r[4];
        return e;
    endfunction

    always_comb begin
        {alu_cout, alu_result} = alu_env(alu_sel, alu_a, alu_b);
    end

    always_comb begin
        {alu_cout_3, alu_result_3} = alu_env(alu_sel_3, alu_a_3, alu_b_3);
        if (glitch) {alu_cout_3, alu_result_3} = ~alu_env(alu_sel_3, alu_a_3, alu_b_3);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
    endtask

    task automatic set_port3(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op_3[i*3 +: 3] = op;
        req_a_3[i*4 +: 4]  = a;
        req_b_3[i*4 +: 4]  = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain1(input string tag);
        for (int c = 0; c < 30 && q1.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(q1.size()), 0);
        for (int c = 0; c < 10 && rsp_valid; c++) @(negedge clk);
        chk({tag, "_idle"}, 32'(rsp_valid), 0);
    endtask

    // Scoreboard: a response is consumed when valid and ready are both high
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q1.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                m1_e = q1.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(m1_e.id));
                chk("rsp_result", 32'(rsp_result), 32'(m1_e.res));
                chk("rsp_cout", 32'(rsp_cout), 32'(m1_e.cout));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid_3 && rsp_ready_3) begin
            if (q3.size() == 0) begin
                chk("rsp3_unexpected", 32'(rsp_valid_3), 0);
            end else begin
                m3_e = q3.pop_front();
                chk("rsp3_id", 32'(rsp_id_3), 32'(m3_e.id));
                chk("rsp3_result", 32'(rsp_result_3), 32'(m3_e.res));
                chk("rsp3_cout", 32'(rsp_cout_3), 32'(m3_e.cout));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        checks = 0;
        errors = 0;
        glitch = 1'b0;
        rst_n  = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req_valid_3 = '0; req_op_3 = '0; req_a_3 = '0; req_b_3 = '0; rsp_ready_3 = 1'b1;

        // Reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'($urandom);
            req_op    = 12'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = 1'($urandom);
            req_valid_3 = 4'($urandom);
            @(negedge clk);
            chk("rst_sel", 32'(alu_sel), 0);
            chk("rst_a", 32'(alu_a), 0);
            chk("rst_b", 32'(alu_b), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_result", 32'(rsp_result), 0);
            chk("rst_rsp_cout", 32'(rsp_cout), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_sel3", 32'(alu_sel_3), 0);
            chk("rst_ready3", 32'(req_ready_3), 0);
            step();
        end
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req_valid_3 = '0;
        rst_n = 1'b1;
        step();

        // Single op from requester 1
        set_port(1, 3'd3, 4'h5, 4'h2);
        req_valid = 4'b0010;
        q1.push_back(mk(2'd1, 3'd3, 4'h5, 4'h2));
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_sel", 32'(alu_sel), 32'h08);
        chk("single_a", 32'(alu_a), 32'h5);
        chk("single_b", 32'(alu_b), 32'h2);
        chk("single_exec_norsp", 32'(rsp_valid), 0);
        chk("single_exec_ready", 32'(req_ready), 0);
        step();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 1);
        chk("single_rsp_sel", 32'(alu_sel), 0);
        step();

        // Reset asserted mid-EXEC: op discarded, no response
        set_port(0, 3'd1, 4'h1, 4'h1);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rme_sel", 32'(alu_sel), 32'h02);
        #1 rst_n = 1'b0;
        #1;
        chk("rme_sel_rst", 32'(alu_sel), 0);
        chk("rme_rsp_rst", 32'(rsp_valid), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rme_no_rsp", 32'(rsp_valid), 0);
        end
        step();

        // Round robin with all four requesting
        set_port(0, 3'd0, 4'h3, 4'h4);
        set_port(1, 3'd1, 4'h2, 4'h5);
        set_port(2, 3'd2, 4'hC, 4'hA);
        set_port(3, 3'd4, 4'hF, 4'h1);
        req_valid = 4'hF;
        q1.push_back(mk(2'd0, 3'd0, 4'h3, 4'h4));
        q1.push_back(mk(2'd1, 3'd1, 4'h2, 4'h5));
        q1.push_back(mk(2'd2, 3'd2, 4'hC, 4'hA));
        q1.push_back(mk(2'd3, 3'd4, 4'hF, 4'h1));
        q1.push_back(mk(2'd0, 3'd0, 4'h3, 4'h4));
        grants = 0;
        for (int c = 0; c < 40 && grants < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                chk("rr_grant", 32'(req_ready), 32'(1) << rr_order[grants]);
                grants++;
            end
        end
        if (grants < 5) chk("rr_timeout", 32'(grants), 5);
        step();
        req_valid = '0;
        drain1("rr_drain");

        // Backpressure: hold RESP for 5 cycles
        step();
        rsp_ready = 1'b0;
        set_port(3, 3'd0, 4'h9, 4'h8);
        req_valid = 4'b1000;
        q1.push_back(mk(2'd3, 3'd0, 4'h9, 4'h8));
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'h8);
        step();
        set_port(0, 3'd5, 4'h6, 4'h0);
        req_valid = 4'b0001;
        q1.push_back(mk(2'd0, 3'd5, 4'h6, 4'h0));
        @(negedge clk);
        chk("bp_exec_ready", 32'(req_ready), 0);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 3);
            chk("bp_result", 32'(rsp_result), 32'h1);
            chk("bp_cout", 32'(rsp_cout), 1);
            chk("bp_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        step();

        // Withdrawn request from 2 while busy, then pointer check
        set_port(2, 3'd2, 4'hF, 4'hF);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("wd_exec_ready", 32'(req_ready), 0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("wd_resp_ready", 32'(req_ready), 0);
        step();
        set_port(1, 3'd6, 4'h9, 4'h0);
        set_port(3, 3'd3, 4'h1, 4'h2);
        req_valid = 4'b1010;
        q1.push_back(mk(2'd1, 3'd6, 4'h9, 4'h0));
        @(negedge clk);
        chk("wd_ptr_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        drain1("wd_drain");

        // EXEC_CYCLES = 3 with a glitch in the first execute cycle
        step();
        set_port3(2, 3'd7, 4'hB, 4'h3);
        req_valid_3 = 4'b0100;
        q3.push_back(mk(2'd2, 3'd7, 4'hB, 4'h3));
        @(negedge clk);
        chk("e3_grant", 32'(req_ready_3), 32'h4);
        step();
        req_valid_3 = '0;
        glitch = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("e3_sel", 32'(alu_sel_3), 32'h80);
            chk("e3_no_rsp", 32'(rsp_valid_3), 0);
            step();
            glitch = 1'b0;
        end
        @(negedge clk);
        chk("e3_sel_done", 32'(alu_sel_3), 0);
        chk("e3_rsp_valid", 32'(rsp_valid_3), 1);
        step();
        @(negedge clk);
        chk("e3_drain", 32'(q3.size()), 0);
        chk("final_q1", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
